// File: rtl/wpu_stream.sv
// wpu_stream: splits each streamed weight into a reduced weight and an optional compensation weight under a per-column budget
module wpu_stream #(
  parameter int WW = 8,
  parameter int MSR = 4,
  parameter int SIZE = 8,
  parameter int CBUDGET = 3,
  localparam int ADDR_W = $clog2(SIZE*SIZE),
  localparam int ROW_W = $clog2(SIZE),
  localparam int COL_W = $clog2(SIZE),
  localparam int CADDR_W = $clog2(SIZE*CBUDGET),
  localparam int CNT_W = $clog2(CBUDGET+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cmp_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WW-1:0]      in_weight,
  output logic               rw_valid,
  output logic [ADDR_W-1:0]  rw_addr,
  output logic [MSR:0]       rw_data,
  output logic               cw_valid,
  output logic [CADDR_W-1:0] cw_addr,
  output logic [WW-MSR-1:0]  cw_data,
  output logic [ROW_W-1:0]   cw_row,
  output logic               cc_valid,
  output logic [COL_W-1:0]   cc_col,
  output logic [CNT_W-1:0]   cc_count,
  output logic [ADDR_W:0]    ovf_count,
  output logic               done
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d, cw_row_q, cw_row_d;
  logic [COL_W-1:0] col_q, col_d, cc_col_q, cc_col_d;
  logic [CNT_W-1:0] slot_q, slot_d, cc_count_q, cc_count_d, slot_inc;
  logic [ADDR_W:0] ovf_q, ovf_d;
  logic cmp_q, cmp_d;
  logic rw_valid_q, rw_valid_d, cw_valid_q, cw_valid_d, cc_valid_q, cc_valid_d, done_q, done_d;
  logic [ADDR_W-1:0] rw_addr_q, rw_addr_d;
  logic [MSR:0] rw_data_q, rw_data_d;
  logic [CADDR_W-1:0] cw_addr_q, cw_addr_d, caddr;
  logic [WW-MSR-1:0] cw_data_q, cw_data_d;
  logic [MSR-1:0] top;
  logic accept, msr, comp, store, last_row, last_col;
  logic lsb_unused;
  assign lsb_unused = in_weight[0];
  assign top = in_weight[WW-1:WW-MSR];
  assign msr = &top | ~|top;
  assign accept = in_valid && state_q == LOAD;
  assign comp = cmp_q && !msr;
  assign store = comp && slot_q < CNT_W'(CBUDGET);
  assign slot_inc = slot_q + CNT_W'(store);
  // SIZE is a power of two, so the last row/column index is all ones
  assign last_row = &row_q;
  assign last_col = &col_q;
  assign caddr = CADDR_W'(col_q) * CADDR_W'(CBUDGET) + CADDR_W'(slot_q);
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    slot_d = slot_q;
    ovf_d = ovf_q;
    cmp_d = cmp_q;
    rw_valid_d = accept;
    cw_valid_d = accept && store;
    cc_valid_d = accept && last_row;
    done_d = accept && last_row && last_col;
    rw_addr_d = accept ? {col_q, row_q} : rw_addr_q;
    rw_data_d = accept ? (comp ? {1'b1, top} : {1'b0, in_weight[MSR:1]}) : rw_data_q;
    cw_addr_d = cw_valid_d ? caddr : cw_addr_q;
    cw_data_d = cw_valid_d ? {in_weight[WW-1], in_weight[WW-MSR-1:1]} : cw_data_q;
    cw_row_d = cw_valid_d ? row_q : cw_row_q;
    cc_col_d = cc_valid_d ? col_q : cc_col_q;
    cc_count_d = cc_valid_d ? slot_inc : cc_count_q;
    if (state_q == IDLE && start) begin
      state_d = LOAD;
      row_d = '0;
      col_d = '0;
      slot_d = '0;
      ovf_d = '0;
      cmp_d = cmp_en;
    end
    if (accept) begin
      row_d = row_q + 1'b1;
      slot_d = last_row ? '0 : slot_inc;
      col_d = last_row ? col_q + 1'b1 : col_q;
      ovf_d = ovf_q + (ADDR_W+1)'(comp && !store);
      state_d = done_d ? IDLE : LOAD;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      slot_q <= '0;
      ovf_q <= '0;
      cmp_q <= 1'b0;
      rw_valid_q <= 1'b0;
      cw_valid_q <= 1'b0;
      cc_valid_q <= 1'b0;
      done_q <= 1'b0;
      rw_addr_q <= '0;
      rw_data_q <= '0;
      cw_addr_q <= '0;
      cw_data_q <= '0;
      cw_row_q <= '0;
      cc_col_q <= '0;
      cc_count_q <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      col_q <= col_d;
      slot_q <= slot_d;
      ovf_q <= ovf_d;
      cmp_q <= cmp_d;
      rw_valid_q <= rw_valid_d;
      cw_valid_q <= cw_valid_d;
      cc_valid_q <= cc_valid_d;
      done_q <= done_d;
      rw_addr_q <= rw_addr_d;
      rw_data_q <= rw_data_d;
      cw_addr_q <= cw_addr_d;
      cw_data_q <= cw_data_d;
      cw_row_q <= cw_row_d;
      cc_col_q <= cc_col_d;
      cc_count_q <= cc_count_d;
    end
  end
  assign in_ready = state_q == LOAD;
  assign rw_valid = rw_valid_q;
  assign rw_addr = rw_addr_q;
  assign rw_data = rw_data_q;
  assign cw_valid = cw_valid_q;
  assign cw_addr = cw_addr_q;
  assign cw_data = cw_data_q;
  assign cw_row = cw_row_q;
  assign cc_valid = cc_valid_q;
  assign cc_col = cc_col_q;
  assign cc_count = cc_count_q;
  assign ovf_count = ovf_q;
  assign done = done_q;
endmodule

// File: tb/tb_wpu_stream.sv
// tb_wpu_stream: directed frames against an acceptance-indexed reference model plus literal spot checks
module tb_wpu_stream;
  localparam int WW = 8, MSR = 4, SIZE = 8, CB = 3;
  logic clk = 0, rst = 1, start = 0, cmp_en = 0, in_valid = 0;
  logic [7:0] in_weight = 0;
  logic in_ready, rw_valid, cw_valid, cc_valid, done;
  logic [5:0] rw_addr;
  logic [4:0] rw_data, cw_addr;
  logic [3:0] cw_data;
  logic [2:0] cw_row, cc_col;
  logic [1:0] cc_count;
  logic [6:0] ovf_count;
  logic s_start = 0, s_cmp = 0, s_valid = 0;
  logic [11:0] s_w = 0;
  logic s_ready, s_rwv, s_cwv, s_ccv, s_done;
  logic [3:0] s_rwa;
  logic [6:0] s_rwd;
  logic [2:0] s_cwa;
  logic [5:0] s_cwd;
  logic [1:0] s_cwr, s_ccc, s_ccn;
  logic [4:0] s_ovf;
  int n_cmp = 0, n_fail = 0;

  wpu_stream dut (
    .clk(clk), .rst(rst), .start(start), .cmp_en(cmp_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_weight(in_weight), .rw_valid(rw_valid), .rw_addr(rw_addr), .rw_data(rw_data),
    .cw_valid(cw_valid), .cw_addr(cw_addr), .cw_data(cw_data), .cw_row(cw_row),
    .cc_valid(cc_valid), .cc_col(cc_col), .cc_count(cc_count), .ovf_count(ovf_count), .done(done)
  );

  wpu_stream #(.WW(12), .MSR(6), .SIZE(4), .CBUDGET(2)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .cmp_en(s_cmp), .in_valid(s_valid), .in_ready(s_ready),
    .in_weight(s_w), .rw_valid(s_rwv), .rw_addr(s_rwa), .rw_data(s_rwd),
    .cw_valid(s_cwv), .cw_addr(s_cwa), .cw_data(s_cwd), .cw_row(s_cwr),
    .cc_valid(s_ccv), .cc_col(s_ccc), .cc_count(s_ccn), .ovf_count(s_ovf), .done(s_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: a weight keeps its sign run iff it fits in WW-MSR+1 signed bits
  function automatic bit f_msr(input logic [7:0] w);
    int s;
    s = int'($signed(w));
    return s >= -(1 << (WW-MSR)) && s < (1 << (WW-MSR));
  endfunction
  function automatic int f_rw(input logic [7:0] w, input bit c);
    return (c && !f_msr(w)) ? (1 << MSR) + (int'(w) >> (WW-MSR)) : (int'(w) >> 1) % (1 << MSR);
  endfunction
  function automatic int f_cw(input logic [7:0] w);
    return (int'(w) >> (WW-1)) * (1 << (WW-MSR-1)) + (int'(w) >> 1) % (1 << (WW-MSR-1));
  endfunction

  bit m_load, m_cmp, e_rwv, e_cwv, e_ccv, e_done;
  int m_k, m_ovf, m_cnt[SIZE];
  int e_rwa, e_rwd, e_cwa, e_cwd, e_cwr, e_ccc, e_ccn;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_load <= 0; m_cmp <= 0; m_k <= 0; m_ovf <= 0; m_cnt <= '{default: 0};
      e_rwv <= 0; e_cwv <= 0; e_ccv <= 0; e_done <= 0;
    end else begin
      e_rwv <= 0; e_cwv <= 0; e_ccv <= 0; e_done <= 0;
      if (!m_load && start) begin
        m_load <= 1; m_k <= 0; m_ovf <= 0; m_cmp <= cmp_en; m_cnt <= '{default: 0};
      end else if (m_load && in_valid) begin
        e_rwv <= 1; e_rwa <= m_k; e_rwd <= f_rw(in_weight, m_cmp);
        if (m_cmp && !f_msr(in_weight) && m_cnt[m_k/SIZE] < CB) begin
          e_cwv <= 1; e_cwa <= (m_k/SIZE)*CB + m_cnt[m_k/SIZE]; e_cwd <= f_cw(in_weight); e_cwr <= m_k%SIZE;
          m_cnt[m_k/SIZE] <= m_cnt[m_k/SIZE] + 1;
        end else if (m_cmp && !f_msr(in_weight)) m_ovf <= m_ovf + 1;
        if (m_k%SIZE == SIZE-1) begin
          e_ccv <= 1; e_ccc <= m_k/SIZE;
          e_ccn <= m_cnt[m_k/SIZE] + ((m_cmp && !f_msr(in_weight) && m_cnt[m_k/SIZE] < CB) ? 1 : 0);
        end
        if (m_k == SIZE*SIZE-1) begin e_done <= 1; m_load <= 0; end
        m_k <= m_k + 1;
      end
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("m_in_ready", in_ready, m_load);
    chk("m_rw_valid", rw_valid, e_rwv);
    chk("m_cw_valid", cw_valid, e_cwv);
    chk("m_cc_valid", cc_valid, e_ccv);
    chk("m_done", done, e_done);
    chk("m_ovf_count", ovf_count, m_ovf);
    if (e_rwv) begin chk("m_rw_addr", rw_addr, e_rwa); chk("m_rw_data", rw_data, e_rwd); end
    if (e_cwv) begin chk("m_cw_addr", cw_addr, e_cwa); chk("m_cw_data", cw_data, e_cwd); chk("m_cw_row", cw_row, e_cwr); end
    if (e_ccv) begin chk("m_cc_col", cc_col, e_ccc); chk("m_cc_count", cc_count, e_ccn); end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0); chk({tag, "_rw_valid"}, rw_valid, 0);
    chk({tag, "_rw_addr"}, rw_addr, 0); chk({tag, "_rw_data"}, rw_data, 0);
    chk({tag, "_cw_valid"}, cw_valid, 0); chk({tag, "_cw_addr"}, cw_addr, 0);
    chk({tag, "_cw_data"}, cw_data, 0); chk({tag, "_cw_row"}, cw_row, 0);
    chk({tag, "_cc_valid"}, cc_valid, 0); chk({tag, "_cc_col"}, cc_col, 0);
    chk({tag, "_cc_count"}, cc_count, 0); chk({tag, "_ovf"}, ovf_count, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] w);
    in_valid = 1; in_weight = w; tick(); in_valid = 0;
  endtask

  task automatic s_push(input logic [11:0] w);
    s_valid = 1; s_w = w; tick(); s_valid = 0;
  endtask

  // mode 1: single-weight vectors, 2: budget overflow, 3: random weights with gaps, 4: compensation disabled
  task automatic run_frame(input int mode, input bit c);
    logic [7:0] w;
    start = 1; cmp_en = c; tick(); start = 0; cmp_en = !c;
    for (int k = 0; k < SIZE*SIZE; k++) begin
      w = mode == 1 ? (k == 0 ? 8'h05 : k == 1 ? 8'hF3 : k == 2 ? 8'h5A : k == 3 ? 8'hA7 : 8'h00)
        : mode == 2 ? (((k >= 1 && k <= 5) || k == 8) ? 8'h5A : 8'h00)
        : mode == 3 ? 8'($urandom) : 8'h5A;
      if (mode == 3) begin
        repeat ($urandom_range(0, 2)) tick();
        start = (k == 10);
      end
      push(w);
      start = 0;
      chk("rw_addr_seq", rw_addr, k);
      chk("done_pulse", done, k == SIZE*SIZE-1);
      if (k%SIZE == SIZE-1) begin chk("cc_fire", cc_valid, 1); chk("cc_col_seq", cc_col, k/SIZE); end
      if (mode == 1 && k == 0) begin chk("w05_rw", rw_data, 5'h02); chk("w05_cwv", cw_valid, 0); end
      if (mode == 1 && k == 1) begin chk("wF3_rw", rw_data, 5'h09); chk("wF3_cwv", cw_valid, 0); end
      if (mode == 1 && k == 2) begin chk("w5A_rw", rw_data, 5'h15); chk("w5A_cwv", cw_valid, 1); chk("w5A_cw", cw_data, 4'h5); end
      if (mode == 1 && k == 3) begin chk("wA7_rw", rw_data, 5'h1A); chk("wA7_cwv", cw_valid, 1); chk("wA7_cw", cw_data, 4'hB); end
      if (mode == 1 && k == 7) chk("f1_cc_count", cc_count, 2);
      if (mode == 2 && k >= 1 && k <= 3) begin chk("ovf_cwv", cw_valid, 1); chk("ovf_cw_addr", cw_addr, k-1); chk("ovf_cw_row", cw_row, k); end
      if (mode == 2 && (k == 4 || k == 5)) chk("ovf_drop_cwv", cw_valid, 0);
      if (mode == 2 && k == 7) begin chk("ovf_cc_count", cc_count, 3); chk("ovf_count", ovf_count, 2); end
      if (mode == 2 && k == 8) begin chk("col1_cw_addr", cw_addr, 3); chk("col1_cw_row", cw_row, 0); end
      if (mode == 4) begin chk("nocmp_rw", rw_data, 5'h0D); chk("nocmp_cwv", cw_valid, 0); end
      if (mode == 4 && k%SIZE == SIZE-1) chk("nocmp_cc_count", cc_count, 0);
    end
    chk("end_in_ready", in_ready, 0);
  endtask

  initial begin
    #12;
    chk_zero("por");
    tick(); rst = 0;
    in_valid = 1; in_weight = 8'h5A; tick(); tick(); in_valid = 0;
    chk("idle_rw_valid", rw_valid, 0);
    s_start = 1; s_cmp = 1; tick(); s_start = 0; s_cmp = 0;
    s_push(12'h3A5);
    chk("p2_rwv", s_rwv, 1); chk("p2_rwa", s_rwa, 0); chk("p2_rwd", s_rwd, 7'h4E);
    chk("p2_cwv", s_cwv, 1); chk("p2_cwa", s_cwa, 0); chk("p2_cwd", s_cwd, 6'h12); chk("p2_cwr", s_cwr, 0);
    s_push(12'h000);
    chk("p2_zero_cwv", s_cwv, 0);
    s_push(12'h3A5);
    chk("p2_cwa1", s_cwa, 1); chk("p2_cwr2", s_cwr, 2);
    s_push(12'h3A5);
    chk("p2_full_cwv", s_cwv, 0); chk("p2_ccv", s_ccv, 1); chk("p2_ccc", s_ccc, 0);
    chk("p2_ccn", s_ccn, 2); chk("p2_ovf", s_ovf, 1); chk("p2_done", s_done, 0); chk("p2_ready", s_ready, 1);
    run_frame(1, 1);
    run_frame(2, 1);
    tick(); tick();
    chk("ovf_hold", ovf_count, 2);
    run_frame(3, 1);
    run_frame(4, 0);
    chk("nocmp_ovf", ovf_count, 0);
    start = 1; cmp_en = 1; tick(); start = 0;
    for (int k = 0; k < 20; k++) push(8'h5A);
    rst = 1; #1;
    chk_zero("midrst");
    tick(); rst = 0;
    chk_zero("postrst");
    run_frame(3, 1);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/wpu_stream.md
# wpu_stream

`wpu_stream` is the parametrised, streaming weight pre-processing unit that sits between the host weight loader and the systolic array's weight and compensation memories. It accepts one SIZE×SIZE weight tile per frame over a valid/ready stream and generates all memory addresses internally. Each weight is split into a reduced weight plus an optional compensation weight, with a programmable per-column compensation budget. It also reports per-column compensation counts and the number of compensations dropped because a column's budget was full.

## Interface
Parameters:
- WW, 8: input weight width, two's complement.
- MSR, 4: number of top bits checked for a uniform sign run; must satisfy 2 ≤ MSR ≤ WW-2.
- SIZE, 8: array dimension; power of two, ≥ 2.
- CBUDGET, 3: compensation slots per column; ≥ 1.
- Derived, not overridable:
  - ADDR_W = clog2(SIZE*SIZE)
  - ROW_W = clog2(SIZE)
  - COL_W = clog2(SIZE)
  - CADDR_W = clog2(SIZE*CBUDGET)
  - CNT_W = clog2(CBUDGET+1)

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse that begins a frame; ignored unless in IDLE.
- cmp_en, in, 1: compensation enable; sampled at start and held for the whole frame.
- in_valid, in, 1: weight valid.
- in_ready, out, 1: unit can accept a weight; combinational, equal to (state==LOAD).
- in_weight, in, WW: weight value.
- rw_valid, out, 1: reduced-weight write strobe.
- rw_addr, out, ADDR_W: reduced-weight memory address.
- rw_data, out, MSR+1: reduced weight.
- cw_valid, out, 1: compensation write strobe.
- cw_addr, out, CADDR_W: compensation memory address.
- cw_data, out, WW-MSR: compensation weight.
- cw_row, out, ROW_W: array row of the compensation.
- cc_valid, out, 1: column-count write strobe.
- cc_col, out, COL_W: index of the completed column.
- cc_count, out, CNT_W: number of compensations stored for that column.
- ovf_count, out, ADDR_W+1: number of dropped compensations in the current frame.
- done, out, 1: one-cycle frame-complete pulse.

## Operation
- FSM has two states, IDLE and LOAD; reset state is IDLE.
- IDLE→LOAD on start. This also clears row, col, slot and ovf_count, and latches cmp_en.
- A weight is accepted on in_valid && in_ready.
- Acceptance order is column-major, with row fastest.
- Addressing for an accepted weight:
  - rw_addr = col*SIZE + row.
  - cw_addr = col*CBUDGET + slot.
- MSR test: msr = the top MSR bits of in_weight are all equal.
- If msr, or if cmp_en was latched low:
  - rw_data = {1'b0, W[MSR:1]}.
  - No compensation is produced.
- Otherwise:
  - rw_data = {1'b1, W[WW-1:WW-MSR]}.
  - If slot < CBUDGET: cw_valid=1, cw_data={W[WW-1], W[WW-MSR-1:1]}, cw_row=row, and slot increments.
  - Else: no compensation write, and ovf_count increments.
- On acceptance of row SIZE-1:
  - cc_valid=1, cc_col=col.
  - cc_count = slot value including this weight's contribution.
  - Slot resets to 0; col increments.
- On acceptance of the last weight (row and col both SIZE-1):
  - done=1 with that weight's outputs.
  - FSM returns to IDLE.
- ovf_count holds its value after done until the next start.
- Reset mid-frame aborts the frame: all state returns to reset values and no done pulse is produced.
- Every output returns to 0 on reset.

## Timing
- Latency is 1 cycle: all outputs for an accepted weight are registered and appear in the cycle after acceptance.
- rw_valid, cw_valid, cc_valid and done are single-cycle strobes; when no weight is accepted, they are 0 in the following cycle.
- Throughput is one weight per cycle with no bubbles, including across column boundaries.
- The frame takes SIZE*SIZE accepting cycles plus 1 cycle of output latency.
- in_ready drops in the cycle after the last weight is accepted.
- start is accepted in the cycle after done; in_ready rises one cycle after start.
- in_valid while in IDLE is ignored, and no output is produced.
- A start pulse asserted while in LOAD is ignored and has no effect on counters.

## Test plan
- Default parameters, cmp_en=1, single weights:
  - 0x05 → rw_data 0x02, no cw.
  - 0xF3 → rw_data 0x09, no cw.
  - 0x5A → rw_data 0x15, cw_data 0x5.
  - 0xA7 → rw_data 0x1A, cw_data 0xB.
- Budget overflow: column 0 rows 1–5 = 0x5A, others 0x00.
  - cw_addr 0,1,2 with cw_row 1,2,3.
  - cc_count=3; ovf_count=2.
  - Column 1 row 0 = 0x5A → cw_addr 3, cw_row 0.
- Full 64-weight frame with random in_valid gaps:
  - rw_addr sequence is 0..63.
  - done occurs exactly once, coincident with rw_addr 63.
  - cc_valid fires 8 times with cc_col 0..7.
- cmp_en=0 frame of all 0x5A:
  - every rw_data = 0x0D.
  - cw_valid is never asserted; ovf_count=0; every cc_count=0.
- Reset asserted after 20 weights:
  - all outputs are 0 and in_ready=0.
  - A new start and frame produce addresses from 0.
- Parameters WW=12, MSR=6, SIZE=4, CBUDGET=2: weight 0x3A5
  - → rw_data 0x4E, cw_data 0x12 at cw_addr 0.
